// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word stream from the configuration host into the loader.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] bs_data;
    logic              bs_valid;
    logic              bs_ready;

    modport master (output bs_data, output bs_valid, input bs_ready);
    modport slave  (input bs_data, input bs_valid, output bs_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain driver: serializes host words LSB-first onto ccff_head,
// optionally reshifts the bitstream and compares CRCs of head and tail bits.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 12,
    parameter int WORD_W    = 8
) (
    input  logic                   prog_clock,
    input  logic                   prog_reset,
    input  logic                   start,
    input  logic                   verify_en,
    ccff_bitstream_loader_if.slave bs,
    output logic                   config_enable,
    output logic                   ccff_head,
    input  logic                   ccff_tail,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            signature
);

    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int SC_W      = $clog2(CHAIN_LEN);
    localparam int RB_W      = $clog2(WORD_W);
    localparam int WC_W      = $clog2(2 * NWORDS + 1);
    localparam int WP_W      = $clog2(NWORDS + 1);

    localparam logic [SC_W-1:0] SC_LAST  = SC_W'(CHAIN_LEN - 1);
    localparam logic [SC_W-1:0] SC_ONE   = SC_W'(1);
    localparam logic [RB_W-1:0] REM_FULL = RB_W'(WORD_W - 1);
    localparam logic [RB_W-1:0] REM_LAST = RB_W'(LAST_BITS - 1);
    localparam logic [RB_W-1:0] REM_ONE  = RB_W'(1);
    localparam logic [WP_W-1:0] WP_LAST  = WP_W'(NWORDS - 1);
    localparam logic [WP_W-1:0] WP_ONE   = WP_W'(1);
    localparam logic [WC_W-1:0] WC_ONCE  = WC_W'(NWORDS);
    localparam logic [WC_W-1:0] WC_TWICE = WC_W'(2 * NWORDS);
    localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              verify_q, verify_d;
    logic [WORD_W-1:0] buf_q, buf_d;       // bits not yet placed on ccff_head
    logic [RB_W-1:0]   rem_q, rem_d;       // count of valid bits in buf_q
    logic [WC_W-1:0]   wrd_q, wrd_d;       // words still to accept, both passes
    logic [WP_W-1:0]   wpos_q, wpos_d;     // word index within the current pass
    logic [SC_W-1:0]   sc_q, sc_d;         // shift cycles done in current pass
    logic [15:0]       crc_h_q, crc_h_d;
    logic [15:0]       crc_t_q, crc_t_d;
    logic              cen_q, cen_d;
    logic              head_q, head_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [15:0]       sig_q, sig_d;

    logic shift_last;
    logic fire;

    assign shift_last = cen_q && (sc_q == SC_LAST);
    assign fire       = bs.bs_valid && ready_q;

    assign config_enable = cen_q;
    assign ccff_head     = head_q;
    assign bs.bs_ready   = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign signature     = sig_q;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return fb ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    endfunction

    // State register
    always_ff @(posedge prog_clock) begin
        if (prog_reset) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next state: passes end on their CHAIN_LEN-th shift cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD:   if (shift_last) state_d = verify_q ? S_VERIFY : S_DONE;
            S_VERIFY: if (shift_last) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs: serializer, word accounting, CRCs
    always_comb begin
        verify_d = verify_q;
        buf_d    = buf_q;
        rem_d    = rem_q;
        wrd_d    = wrd_q;
        wpos_d   = wpos_q;
        sc_d     = sc_q;
        crc_h_d  = crc_h_q;
        crc_t_d  = crc_t_q;
        head_d   = head_q;
        cen_d    = 1'b0;
        done_d   = 1'b0;
        pass_d   = 1'b0;
        sig_d    = sig_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    verify_d = verify_en;
                    wrd_d    = verify_en ? WC_TWICE : WC_ONCE;
                    wpos_d   = '0;
                    rem_d    = '0;
                    sc_d     = '0;
                    crc_h_d  = 16'hFFFF;
                    crc_t_d  = 16'hFFFF;
                    head_d   = 1'b0;
                end
            end
            S_LOAD, S_VERIFY: begin
                if (cen_q) begin
                    sc_d = shift_last ? '0 : sc_q + SC_ONE;
                    if (state_q == S_LOAD) crc_h_d = crc_step(crc_h_q, head_q);
                    else                   crc_t_d = crc_step(crc_t_q, ccff_tail);
                end
                if (rem_q != '0) begin
                    head_d = buf_q[0];
                    buf_d  = buf_q >> 1;
                    rem_d  = rem_q - REM_ONE;
                    cen_d  = 1'b1;
                end else if (fire) begin
                    // Short last word of a pass: only its low LAST_BITS bits count
                    head_d = bs.bs_data[0];
                    buf_d  = bs.bs_data >> 1;
                    rem_d  = (wpos_q == WP_LAST) ? REM_LAST : REM_FULL;
                    wpos_d = (wpos_q == WP_LAST) ? '0 : wpos_q + WP_ONE;
                    wrd_d  = wrd_q - WC_ONE;
                    cen_d  = 1'b1;
                end
                if (shift_last && (state_q == S_VERIFY || !verify_q)) begin
                    done_d = 1'b1;
                    pass_d = verify_q ? (crc_h_d == crc_t_d) : 1'b1;
                    sig_d  = crc_h_d;
                end
            end
            S_DONE:  head_d = 1'b0;
            default: ;
        endcase
        // Ready also in the cycle whose head bit is the last buffered one
        ready_d = (state_d == S_LOAD || state_d == S_VERIFY) &&
                  (rem_d == '0) && (wrd_d != '0);
        busy_d  = (state_d != S_IDLE);
    end

    // Datapath registers; reset clears every output including the signature
    always_ff @(posedge prog_clock) begin
        if (prog_reset) begin
            verify_q <= 1'b0;
            buf_q    <= '0;
            rem_q    <= '0;
            wrd_q    <= '0;
            wpos_q   <= '0;
            sc_q     <= '0;
            crc_h_q  <= '0;
            crc_t_q  <= '0;
            cen_q    <= 1'b0;
            head_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            sig_q    <= '0;
        end else begin
            verify_q <= verify_d;
            buf_q    <= buf_d;
            rem_q    <= rem_d;
            wrd_q    <= wrd_d;
            wpos_q   <= wpos_d;
            sc_q     <= sc_d;
            crc_h_q  <= crc_h_d;
            crc_t_q  <= crc_t_d;
            cen_q    <= cen_d;
            head_q   <= head_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            sig_q    <= sig_d;
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboarded bench: a 12-bit chain model, directed runs, monitor on done.
module tb_ccff_bitstream_loader;

    localparam int L  = 12;
    localparam int WW = 8;
    localparam logic [L-1:0]  STUCK_MASK = ~(L'(1) << 5);
    localparam logic [L-1:0]  EXP_CHAIN  = 12'b1010_0101_1100;
    localparam logic [L-1:0]  STREAM     = 12'h3A5;   // bit k = k-th head bit

    logic        prog_clock = 1'b0;
    logic        prog_reset, start, verify_en;
    logic        config_enable, ccff_head, ccff_tail, busy, done, pass;
    logic [15:0] signature;

    ccff_bitstream_loader_if #(.WORD_W(WW)) bs_if ();

    ccff_bitstream_loader #(.CHAIN_LEN(L), .WORD_W(WW)) dut (
        .prog_clock    (prog_clock),
        .prog_reset    (prog_reset),
        .start         (start),
        .verify_en     (verify_en),
        .bs            (bs_if),
        .config_enable (config_enable),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .signature     (signature)
    );

    always #5 prog_clock = ~prog_clock;

    // Behavioural chain, with optional stuck-at-0 at position 5
    logic [L-1:0] chain = '0;
    logic         stuck = 1'b0;
    always @(posedge prog_clock)
        if (config_enable) chain <= {chain[L-2:0], ccff_head} & (stuck ? STUCK_MASK : '1);
    assign ccff_tail = chain[L-1];

    int cyc = 0;
    always @(posedge prog_clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic        ok;
        logic [15:0] sig;
        int          shifts;
        int          gaps;
        int          lat;
    } exp_t;
    exp_t sb[$];
    int   n_exp  = 0;
    int   n_done = 0;

    function automatic logic [15:0] crc_ref();
        logic [15:0] c;
        logic [L-1:0] s;
        c = 16'hFFFF;
        s = STREAM;
        for (int k = 0; k < L; k++)
            c = (c[15] ^ s[k]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction

    // Monitor: run statistics, pops the scoreboard on every done pulse
    int   run_shifts = 0, run_first = -1, run_last = -1, start_cyc = 0;
    logic prev_busy = 1'b0, after_done = 1'b0;
    always begin
        @(posedge prog_clock);
        #1;
        if (after_done) begin
            chk("busy_low_after_done", busy, 0);
            chk("done_one_cycle", done, 0);
            after_done = 1'b0;
        end
        if (busy && !prev_busy) begin
            start_cyc  = cyc;
            run_shifts = 0;
            run_first  = -1;
        end
        if (config_enable) begin
            run_shifts++;
            if (run_first < 0) run_first = cyc;
            run_last = cyc;
        end
        if (done) begin
            n_done++;
            after_done = 1'b1;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pass", pass, e.ok);
                chk("signature", signature, e.sig);
                chk("shift_count", run_shifts, e.shifts);
                chk("shift_gaps", run_last - run_first + 1 - run_shifts, e.gaps);
                chk("done_latency", cyc - start_cyc, e.lat);
                chk("busy_with_done", busy, 1);
            end
        end
        prev_busy = busy;
    end

    task automatic pulse_start(input logic v);
        start     = 1'b1;
        verify_en = v;
        @(negedge prog_clock);
        start     = 1'b0;
        verify_en = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] d);
        int t;
        t = 0;
        bs_if.bs_valid = 1'b1;
        bs_if.bs_data  = d;
        while (!bs_if.bs_ready && t < 60) begin
            @(negedge prog_clock);
            t++;
        end
        if (t >= 60) chk("ready_timeout", 0, 1);
        @(negedge prog_clock);
        bs_if.bs_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!bs_if.bs_ready && t < 60) begin
            @(negedge prog_clock);
            t++;
        end
        if (t >= 60) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge prog_clock);
            t++;
        end
        if (t >= 300) chk("done_timeout", 0, 1);
        repeat (2) @(negedge prog_clock);
    endtask

    // One complete run; gap inserts a 5-cycle underrun, stray pulses start mid-LOAD
    task automatic run(input logic v, input logic stk, input logic gap, input logic stray);
        exp_t e;
        stuck    = stk;
        e.ok     = !stk;
        e.sig    = crc_ref();
        e.shifts = v ? 2 * L : L;
        e.gaps   = gap ? 5 : 0;
        e.lat    = (v ? 2 * L : L) + 1 + (gap ? 5 : 0);
        sb.push_back(e);
        n_exp++;
        pulse_start(v);
        chk("ready_after_start", bs_if.bs_ready, 1);
        for (int p = 0; p < (v ? 2 : 1); p++) begin
            send_word(8'hA5);
            if (stray && p == 0) pulse_start(1'b1);
            if (gap && p == 0) begin
                wait_ready();
                repeat (5) @(negedge prog_clock);
            end
            send_word(8'h03);
        end
        wait_done();
        if (!stk) chk("chain_contents", chain, EXP_CHAIN);
        stuck = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_config_enable"}, config_enable, 0);
        chk({tag, "_ccff_head"}, ccff_head, 0);
        chk({tag, "_bs_ready"}, bs_if.bs_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_signature"}, signature, 0);
    endtask

    initial begin
        prog_reset     = 1'b1;
        start          = 1'b0;
        verify_en      = 1'b0;
        bs_if.bs_valid = 1'b0;
        bs_if.bs_data  = '0;
        repeat (3) @(negedge prog_clock);
        chk_all_zero("reset");
        prog_reset = 1'b0;
        @(negedge prog_clock);

        run(1'b0, 1'b0, 1'b0, 1'b0);   // load only
        run(1'b1, 1'b0, 1'b0, 1'b0);   // load + verify
        run(1'b1, 1'b1, 1'b0, 1'b0);   // verify with stuck-at-0
        run(1'b0, 1'b0, 1'b1, 1'b0);   // underrun after first word

        // Reset after 5 shift cycles of LOAD
        pulse_start(1'b0);
        send_word(8'hA5);               // returns in shift cycle 1
        repeat (4) @(negedge prog_clock);
        chk("pre_reset_shifting", config_enable, 1);
        prog_reset = 1'b1;
        @(negedge prog_clock);
        chk_all_zero("midreset");
        prog_reset = 1'b0;
        @(negedge prog_clock);

        run(1'b0, 1'b0, 1'b0, 1'b0);   // fresh start after reset
        run(1'b0, 1'b0, 1'b0, 1'b1);   // stray start during LOAD

        repeat (4) @(negedge prog_clock);
        chk("scoreboard_empty", sb.size(), 0);
        chk("done_count", n_done, n_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
